key_debounce_multi: RTL and testbench

//  N-channel key debouncer: next generation of the single-key debouncer (key/led/count).
//  Per channel: sync raw active-low key, filter bounce, emit one-cycle press/release pulses.

---
 rtl/key_debounce_multi_pkg.sv | 23 ++
 rtl/key_debounce_ch.sv | 187 ++++++++++++++++++
 rtl/key_debounce_multi.sv | 56 +++++
 tb/tb_key_debounce_multi.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_multi_pkg.sv
// -----------------------------------------------------------------------------
// key_debounce_multi_pkg
// Shared definitions for the multi-channel key debouncer:
//   - per-channel FSM state encoding
//   - default timing constants for a 50 MHz system clock
// No ports (package).
// -----------------------------------------------------------------------------
package key_debounce_multi_pkg;

    // Per-channel key FSM states
    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_LONG     = 2'd2
    } key_fsm_e;

    // Defaults for 50 MHz: 20 ms debounce window, 1 s long-press threshold
    localparam int DEF_N_KEYS      = 4;
    localparam int DEF_DEB_CYCLES  = 1_000_000;
    localparam int DEF_LONG_CYCLES = 50_000_000;
    localparam int DEF_CNT_W       = 10;

endpackage

// File: rtl/key_debounce_ch.sv
// -----------------------------------------------------------------------------
// key_debounce_ch
// One key channel: 2-FF synchroniser, bounce filter, press/release/long FSM,
// toggling LED and wrapping press counter. All outputs are registered.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active low
//   key        in   raw key, active low (1 = released), asynchronous
//   cnt_clr    in   synchronous clear of the press counter (beats increment)
//   key_state  out  debounced level, 1 = pressed
//   press_p    out  one-cycle pulse on accepted press
//   release_p  out  one-cycle pulse on accepted release
//   long_press out  high while held past LONG_CYCLES, cleared on release
//   led        out  toggles on every accepted press
//   count      out  press counter, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module key_debounce_ch
    import key_debounce_multi_pkg::*;
#(
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int LONG_CYCLES = DEF_LONG_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key,
    input  logic             cnt_clr,
    output logic             key_state,
    output logic             press_p,
    output logic             release_p,
    output logic             long_press,
    output logic             led,
    output logic [CNT_W-1:0] count
);

    localparam int DEB_W  = $clog2(DEB_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

    // Next press-counter value; a clear wins over a simultaneous press
    function automatic logic [CNT_W-1:0] count_next(
        input logic [CNT_W-1:0] cur,
        input logic             clr,
        input logic             inc
    );
        logic [CNT_W-1:0] nxt;
        if (clr) begin
            nxt = {CNT_W{1'b0}};
        end else if (inc) begin
            nxt = cur + CNT_W'(1);
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    logic              sync1_q, sync2_q;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              key_state_q, key_state_d;
    key_fsm_e          state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              press_p_q, press_p_d;
    logic              release_p_q, release_p_d;
    logic              long_press_q, long_press_d;
    logic              led_q, led_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic pressed_s, differs_s, accept_s, press_evt_s, release_evt_s;

    // Two-stage synchroniser, preset to the released level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
        end
    end

    // Bounce filter: a change is accepted only after DEB_CYCLES consecutive
    // samples that disagree with the current debounced level
    always_comb begin
        pressed_s     = ~sync2_q;
        differs_s     = pressed_s ^ key_state_q;
        accept_s      = differs_s && (deb_cnt_q == DEB_MAX);
        press_evt_s   = accept_s && !key_state_q;
        release_evt_s = accept_s && key_state_q;
        if (!differs_s || accept_s) begin
            deb_cnt_d = {DEB_W{1'b0}};
        end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
        if (accept_s) begin
            key_state_d = ~key_state_q;
        end else begin
            key_state_d = key_state_q;
        end
    end

    // Key FSM next state, hold timer and registered output values
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        long_press_d = long_press_q;
        case (state_q)
            ST_RELEASED: begin
                if (press_evt_s) begin
                    state_d    = ST_PRESSED;
                    hold_cnt_d = {HOLD_W{1'b0}};
                end else begin
                    state_d    = ST_RELEASED;
                end
            end
            ST_PRESSED: begin
                // A release on the same cycle the hold expires wins
                if (release_evt_s) begin
                    state_d      = ST_RELEASED;
                    hold_cnt_d   = {HOLD_W{1'b0}};
                    long_press_d = 1'b0;
                end else if (hold_cnt_q == HOLD_MAX) begin
                    state_d      = ST_LONG;
                    long_press_d = 1'b1;
                end else begin
                    hold_cnt_d   = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_LONG: begin
                // hold_cnt is left saturated while in LONG
                if (release_evt_s) begin
                    state_d      = ST_RELEASED;
                    hold_cnt_d   = {HOLD_W{1'b0}};
                    long_press_d = 1'b0;
                end else begin
                    state_d      = ST_LONG;
                end
            end
            default: begin
                state_d      = ST_RELEASED;
                hold_cnt_d   = {HOLD_W{1'b0}};
                long_press_d = 1'b0;
            end
        endcase
        press_p_d   = press_evt_s;
        release_p_d = release_evt_s;
        if (press_evt_s) begin
            led_d = ~led_q;
        end else begin
            led_d = led_q;
        end
        count_d = count_next(count_q, cnt_clr, press_evt_s);
    end

    // Filter, FSM and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_cnt_q    <= {DEB_W{1'b0}};
            key_state_q  <= 1'b0;
            state_q      <= ST_RELEASED;
            hold_cnt_q   <= {HOLD_W{1'b0}};
            press_p_q    <= 1'b0;
            release_p_q  <= 1'b0;
            long_press_q <= 1'b0;
            led_q        <= 1'b0;
            count_q      <= {CNT_W{1'b0}};
        end else begin
            deb_cnt_q    <= deb_cnt_d;
            key_state_q  <= key_state_d;
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            press_p_q    <= press_p_d;
            release_p_q  <= release_p_d;
            long_press_q <= long_press_d;
            led_q        <= led_d;
            count_q      <= count_d;
        end
    end

    assign key_state  = key_state_q;
    assign press_p    = press_p_q;
    assign release_p  = release_p_q;
    assign long_press = long_press_q;
    assign led        = led_q;
    assign count      = count_q;

endmodule

// File: rtl/key_debounce_multi.sv
// -----------------------------------------------------------------------------
// key_debounce_multi
// N_KEYS independent debounced key channels; this level only replicates
// key_debounce_ch and packs its outputs.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active low
//   key        in   [N_KEYS]        raw keys, active low
//   cnt_clr    in   [N_KEYS]        per-channel press counter clear
//   key_state  out  [N_KEYS]        debounced levels, 1 = pressed
//   press_p    out  [N_KEYS]        press pulses
//   release_p  out  [N_KEYS]        release pulses
//   long_press out  [N_KEYS]        long-press flags
//   led        out  [N_KEYS]        toggling LEDs
//   count      out  [N_KEYS*CNT_W]  press counters, ch i at [i*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module key_debounce_multi
    import key_debounce_multi_pkg::*;
#(
    parameter int N_KEYS      = DEF_N_KEYS,
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int LONG_CYCLES = DEF_LONG_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_KEYS-1:0]       key,
    input  logic [N_KEYS-1:0]       cnt_clr,
    output logic [N_KEYS-1:0]       key_state,
    output logic [N_KEYS-1:0]       press_p,
    output logic [N_KEYS-1:0]       release_p,
    output logic [N_KEYS-1:0]       long_press,
    output logic [N_KEYS-1:0]       led,
    output logic [N_KEYS*CNT_W-1:0] count
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEB_CYCLES (DEB_CYCLES),
            .LONG_CYCLES(LONG_CYCLES),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .key       (key[i]),
            .cnt_clr   (cnt_clr[i]),
            .key_state (key_state[i]),
            .press_p   (press_p[i]),
            .release_p (release_p[i]),
            .long_press(long_press[i]),
            .led       (led[i]),
            .count     (count[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
module tb_key_debounce_multi;

    localparam int N    = 4;
    localparam int DEB  = 16;
    localparam int LONG = 64;
    localparam int CW   = 4;
    localparam int MAXC = 40000;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    key;
    logic [N-1:0]    cnt_clr;
    logic [N-1:0]    key_state, press_p, release_p, long_press, led;
    logic [N*CW-1:0] count;

    key_debounce_multi #(
        .N_KEYS(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .key(key), .cnt_clr(cnt_clr),
        .key_state(key_state), .press_p(press_p), .release_p(release_p),
        .long_press(long_press), .led(led), .count(count)
    );

    always #10 clk = ~clk;

    typedef struct {
        int   cyc;
        int   ch;
        logic pr, rl, lg, ks, ld;
        int   cnt;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: whole sample history, acceptance = "the last DEB
    // synchronised samples all disagree with the debounced level"
    int   cyc = 0;
    int   rel_edge = 0;
    logic hist [N][MAXC];
    logic m_st [N];
    logic m_long [N];
    logic m_led [N];
    int   m_cnt [N];
    int   m_press_at [N];

    function automatic logic filt_at(input int c, input int idx);
        if (idx > rel_edge) return hist[c][idx];
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < N; c++) begin
                m_st[c] = 1'b0; m_long[c] = 1'b0; m_led[c] = 1'b0;
                m_cnt[c] = 0;   m_press_at[c] = 0;
            end
            rel_edge = cyc;
        end else begin
            cyc++;
            if (cyc >= MAXC) begin
                $display("FAIL budget: cycle %0d exceeds history %0d", cyc, MAXC);
                $fatal(1, "history overflow");
            end
            for (int c = 0; c < N; c++) hist[c][cyc] = ~key[c];
            for (int c = 0; c < N; c++) begin
                logic acc, pr, rl, lg_prev;
                acc = 1'b1;
                for (int k = 0; k < DEB; k++)
                    if (filt_at(c, cyc - 2 - k) == m_st[c]) acc = 1'b0;
                pr = acc && !m_st[c];
                rl = acc && m_st[c];
                lg_prev = m_long[c];
                if (rl) m_long[c] = 1'b0;
                else if (m_st[c] && !m_long[c] && (cyc - m_press_at[c] == LONG)) m_long[c] = 1'b1;
                if (pr) begin
                    m_led[c] = ~m_led[c];
                    m_press_at[c] = cyc;
                end
                if (cnt_clr[c]) m_cnt[c] = 0;
                else if (pr) m_cnt[c] = (m_cnt[c] + 1) % (1 << CW);
                if (acc) m_st[c] = ~m_st[c];
                if (pr || rl || (m_long[c] != lg_prev))
                    sb_q.push_back('{cyc, c, pr, rl, m_long[c], m_st[c], m_led[c], m_cnt[c]});
            end
        end
    end

    // Monitor: level check every cycle, event pop whenever a pulse or long flag change appears
    logic mon_long [N];
    initial for (int c = 0; c < N; c++) mon_long[c] = 1'b0;

    always @(negedge clk) begin
        for (int c = 0; c < N; c++) begin
            logic [3:0] want, got;
            want = {m_st[c], m_led[c], m_long[c], 1'b0};
            got  = {key_state[c], led[c], long_press[c], 1'b0};
            vectors++;
            if (want != got || count[c*CW +: CW] != CW'(m_cnt[c])) begin
                miscompares++;
                $display("FAIL levels ch%0d t=%0t: ks/led/long=%b cnt=%0d, want %b cnt=%0d",
                         c, $time, got[3:1], count[c*CW +: CW], want[3:1], m_cnt[c]);
            end
        end
        if (rst) begin
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                vectors++; miscompares++;
                $display("FAIL missed_event ch%0d cyc%0d: got nothing, want event", sb_q[0].ch, sb_q[0].cyc);
                void'(sb_q.pop_front());
            end
            for (int c = 0; c < N; c++) begin
                logic ev, have;
                ev   = press_p[c] | release_p[c] | (long_press[c] != mon_long[c]);
                have = (sb_q.size() > 0) && (sb_q[0].cyc == cyc) && (sb_q[0].ch == c);
                mon_long[c] = long_press[c];
                if (ev || have) begin
                    vectors++;
                    if (ev && have) begin
                        exp_t e;
                        e = sb_q.pop_front();
                        if (e.pr != press_p[c] || e.rl != release_p[c] || e.lg != long_press[c] ||
                            e.ks != key_state[c] || e.ld != led[c] || CW'(e.cnt) != count[c*CW +: CW]) begin
                            miscompares++;
                            $display("FAIL event ch%0d cyc%0d: got pr=%b rl=%b lg=%b ks=%b led=%b cnt=%0d, want pr=%b rl=%b lg=%b ks=%b led=%b cnt=%0d",
                                     c, cyc, press_p[c], release_p[c], long_press[c], key_state[c], led[c],
                                     count[c*CW +: CW], e.pr, e.rl, e.lg, e.ks, e.ld, e.cnt);
                        end
                    end else if (ev) begin
                        miscompares++;
                        $display("FAIL unexpected_event ch%0d cyc%0d: got pr=%b rl=%b lg=%b, want no event",
                                 c, cyc, press_p[c], release_p[c], long_press[c]);
                    end else begin
                        void'(sb_q.pop_front());
                        miscompares++;
                        $display("FAIL missed_event ch%0d cyc%0d: got no event, want event", c, cyc);
                    end
                end
            end
        end else begin
            for (int c = 0; c < N; c++) mon_long[c] = 1'b0;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // 20 toggles 1 time unit apart, skipping any instant that coincides with a rising edge
    task automatic bounce(input int ch, input logic fin);
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((($time - 10) % 20) == 0) #1;
            key[ch] = ~key[ch];
        end
        key[ch] = fin;
    endtask

    initial begin
        rst = 1'b0; key = 4'hF; cnt_clr = 4'h0;
        // 1: reset, keys wiggled while held in reset
        cycles(5);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #3; key = 4'($urandom);
        end
        @(negedge clk); key = 4'hF;
        @(negedge clk); #2; rst = 1'b1;
        cycles(5);
        // 2: bouncy press and release on ch0
        @(posedge clk); bounce(0, 1'b0); cycles(30);
        @(posedge clk); bounce(0, 1'b1); cycles(30);
        // 3: 15-cycle glitch on ch1
        key[1] = 1'b0; cycles(15); key[1] = 1'b1; cycles(25);
        // 4: long press on ch2
        key[2] = 1'b0; cycles(100); key[2] = 1'b1; cycles(30);
        // 5: 17 presses wrap the 4-bit counter, then a clear on the press cycle
        for (int i = 0; i < 17; i++) begin
            key[3] = 1'b0; cycles(22); key[3] = 1'b1; cycles(22);
        end
        key[3] = 1'b0;
        repeat (17) @(posedge clk);
        #2; cnt_clr[3] = 1'b1;
        @(posedge clk); #2; cnt_clr[3] = 1'b0;
        cycles(10); key[3] = 1'b1; cycles(25);
        // 6: all keys together, reset during long press with keys held
        key = 4'h0; cycles(90);
        @(negedge clk); #2; rst = 1'b0;
        cycles(3); #2; rst = 1'b1;
        cycles(40); key = 4'hF; cycles(30);
        // Random phase
        for (int it = 0; it < 250; it++) begin
            int ch, mode;
            ch   = $urandom_range(0, N - 1);
            mode = $urandom_range(0, 3);
            case (mode)
                0: begin @(negedge clk); key[ch] = ~key[ch]; end
                1: begin @(posedge clk); bounce(ch, logic'($urandom_range(0, 1))); end
                2: begin
                    @(negedge clk); key[ch] = ~key[ch];
                    cycles($urandom_range(1, 20)); key[ch] = ~key[ch];
                end
                default: begin
                    @(negedge clk); cnt_clr = 4'($urandom);
                    @(negedge clk); cnt_clr = 4'h0;
                end
            endcase
            cycles($urandom_range(1, 40));
        end
        key = 4'hF; cnt_clr = 4'h0;
        cycles(40);
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected events never presented, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
